// File: rtl/fifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_rr_arbiter
//
// Round-robin arbiter that shares one downstream valid/ready consumer between
// N upstream fifos. Once a requester is granted, its head-of-queue beat is
// passed straight through to the output. The grant lasts for a bounded burst.
// After the burst, priority rotates to the requester after the one that was
// granted, so no queue starves.
//
// Optional feature macro: ARB_LAST_LOCK_EN
//   When defined, a grant is held until a beat with req_last set is
//   transferred, and MAX_BURST is ignored. The grant is still released when
//   the granted queue drains.
//
// Parameters
//   WIDTH      data width per requester
//   N          number of requesters (>= 2)
//   MAX_BURST  maximum transfers per grant (>= 1)
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   req_data   requester i data at [i*WIDTH +: WIDTH]
//   req_val    per-requester valid (fifo data_out_val)
//   req_last   per-requester end-of-packet marker for the head beat
//   req_rdy    per-requester pop qualifier (fifo data_out_rdy)
//   out_data   granted requester's data
//   out_val    output valid
//   out_last   req_last of the granted requester
//   out_rdy    downstream ready
//   out_src    index of the current (or most recent) grant, registered
//   busy       high while a grant is active
// -----------------------------------------------------------------------------
module fifo_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int N         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   req_data,
    input  logic [N-1:0]         req_val,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_rdy,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_val,
    output logic                 out_last,
    input  logic                 out_rdy,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         r_state, w_state_next;
    logic [IW-1:0]  r_g, w_g_next;
    logic [IW-1:0]  r_ptr, w_ptr_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;

    logic [WIDTH-1:0] w_data [N];
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_g_inc;
    logic             w_grant;
    logic             w_head_val;
    logic             w_xfer;

    // Index addition that wraps at N-1 -> 0, so that non-power-of-two N never
    // produces an out-of-range index. Both operands are always below N.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The first valid requester scanning ptr, ptr+1, ... modulo N. The loop
    // runs from the far end towards ptr so that the nearest match wins.
    always_comb begin
        w_pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_val[wrap_add(r_ptr, k)]) begin
                w_pick = wrap_add(r_ptr, k);
            end
        end
    end

    assign w_g_inc    = wrap_add(r_g, 1);
    assign w_grant    = (r_state == GRANT);
    assign w_head_val = req_val[r_g];
    assign w_xfer     = w_grant && w_head_val && out_rdy;

    // The output path is combinational from the requester inputs while a
    // grant is active, and is quiet otherwise.
    always_comb begin
        out_val  = 1'b0;
        out_data = '0;
        out_last = 1'b0;
        req_rdy  = '0;
        if (w_grant) begin
            out_val  = w_head_val;
            out_data = w_data[r_g];
            out_last = req_last[r_g];
            if (out_rdy) begin
                req_rdy = N'(1) << r_g;
            end
        end
    end

    assign out_src = r_g;
    assign busy    = w_grant;

    always_comb begin
        w_state_next = r_state;
        w_g_next     = r_g;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (|req_val) begin
                    w_state_next = GRANT;
                    w_g_next     = w_pick;
                    w_cnt_next   = '0;
                end
            end
            GRANT: begin
                if (!w_head_val) begin
                    // When the queue drains, the grant is released at once.
                    // This avoids dead cycles that would wait on an empty fifo.
                    w_state_next = IDLE;
                    w_ptr_next   = w_g_inc;
                    w_cnt_next   = '0;
                end else if (w_xfer) begin
`ifdef ARB_LAST_LOCK_EN
                    if (req_last[r_g]) begin
                        w_state_next = IDLE;
                        w_ptr_next   = w_g_inc;
                        w_cnt_next   = '0;
                    end else if (r_cnt != CW'(MAX_BURST)) begin
                        // The count only saturates here. A packet can be
                        // longer than MAX_BURST.
                        w_cnt_next = r_cnt + 1'b1;
                    end
`else
                    if (r_cnt == CW'(MAX_BURST - 1)) begin
                        w_state_next = IDLE;
                        w_ptr_next   = w_g_inc;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
`endif
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_g     <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_g     <= w_g_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_val = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   out_data;
    logic           out_val;
    logic           out_last;
    logic           out_rdy = 1'b0;
    logic [1:0]     out_src;
    logic           busy;

    // Second instance with N=3, which checks the index wrap.
    logic [3*W-1:0] d3 = '0;
    logic [2:0]     v3 = '0;
    logic [2:0]     l3 = '0;
    logic [2:0]     rdy3;
    logic [W-1:0]   od3;
    logic           ov3;
    logic           ol3;
    logic           ordy3 = 1'b0;
    logic [1:0]     src3;
    logic           busy3;

    fifo_rr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_val(req_val),
        .req_last(req_last), .req_rdy(req_rdy), .out_data(out_data),
        .out_val(out_val), .out_last(out_last), .out_rdy(out_rdy),
        .out_src(out_src), .busy(busy)
    );

    fifo_rr_arbiter #(.WIDTH(W), .N(3), .MAX_BURST(4)) dut3 (
        .clk(clk), .reset(reset), .req_data(d3), .req_val(v3),
        .req_last(l3), .req_rdy(rdy3), .out_data(od3),
        .out_val(ov3), .out_last(ol3), .out_rdy(ordy3),
        .out_src(src3), .busy(busy3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ld_src;   // requester to load before this cycle, -1 for none
        int ld_n;     // number of beats loaded
        bit rdy;      // out_rdy driven
        bit busy;     // expected busy
        bit val;      // expected out_val
        int src;      // expected out_src
    } vec_t;

    vec_t tbl[$];
    int   rem[N];     // beats still queued per requester
    int   seq[N];     // beats popped so far per requester
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int ls, input int ln, input bit r, input bit b,
                                input bit v, input int s, input int n = 1);
        for (int i = 0; i < n; i++) begin
            tbl.push_back('{(i == 0) ? ls : -1, ln, r, b, v, s});
        end
    endfunction

    // Each fifo presents its head beat as {index, sequence number}. The last
    // queued beat carries req_last.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_val[i]          = (rem[i] > 0);
            req_last[i]         = (rem[i] == 1);
            req_data[i*W +: W]  = {8'(i), 24'(seq[i])};
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        out_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        drive();
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst out_val", out_val, 0);
        check("rst out_src", out_src, 0);
        check("rst req_rdy", req_rdy, 0);
        check("rst out_last", out_last, 0);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int k);
        vec_t       v;
        logic [3:0] pop;
        logic [3:0] emask;
        bit         elast;
        v = tbl[k];
        @(negedge clk);
        if (v.ld_src >= 0) rem[v.ld_src] = v.ld_n;
        out_rdy = v.rdy;
        drive();
        #1;
        emask = (v.busy && v.rdy) ? 4'(1 << v.src) : 4'b0;
        elast = v.busy && (rem[v.src] == 1);
        check($sformatf("vec%0d busy", k), busy, v.busy);
        check($sformatf("vec%0d out_val", k), out_val, v.val);
        check($sformatf("vec%0d out_src", k), out_src, v.src);
        check($sformatf("vec%0d req_rdy", k), req_rdy, emask);
        check($sformatf("vec%0d out_last", k), out_last, elast);
        if (v.val) begin
            check($sformatf("vec%0d out_data", k), out_data, {8'(v.src), 24'(seq[v.src])});
        end
        pop = req_rdy & req_val;
        $display("[TB] vec%0d rdy=%0d busy=%0b val=%0b src=%0d data=%08h",
                 k, v.rdy, busy, out_val, out_src, out_data);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                rem[i]--;
                seq[i]++;
            end
        end
    endtask

    task automatic run_range(input int a, input int b);
        for (int k = a; k < b; k++) run_vec(k);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int s0, s1, s2, s3, s4;
`ifndef ARB_LAST_LOCK_EN
        // A: single requester 2, 10 beats, giving bursts of 4, 4 and 2.
        s0 = tbl.size();
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 2, 4);
        add(-1, 0, 1, 0, 0, 2);
        add(-1, 0, 1, 1, 1, 2, 4);
        add(-1, 0, 1, 0, 0, 2);
        add(-1, 0, 1, 1, 1, 2, 2);
        add(-1, 0, 1, 1, 0, 2);          // the queue has drained, so release
        add(-1, 0, 1, 0, 0, 2);
        // B: all four requesters continuously valid, order 0,1,2,3,0.
        s1 = tbl.size();
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 0, 4);
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 1, 4);
        add(-1, 0, 1, 0, 0, 1);
        add(-1, 0, 1, 1, 1, 2, 4);
        add(-1, 0, 1, 0, 0, 2);
        add(-1, 0, 1, 1, 1, 3, 4);
        add(-1, 0, 1, 0, 0, 3);
        add(-1, 0, 1, 1, 1, 0, 4);
        // C: backpressure on requester 1 (6 beats).
        s2 = tbl.size();
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 1);
        add(-1, 0, 0, 1, 1, 1);
        add(-1, 0, 1, 1, 1, 1);
        add(-1, 0, 0, 1, 1, 1);
        add(-1, 0, 1, 1, 1, 1);
        add(-1, 0, 0, 1, 1, 1);
        add(-1, 0, 1, 1, 1, 1);          // 4th transfer, so release
        add(-1, 0, 0, 0, 0, 1);
        add(-1, 0, 1, 1, 1, 1, 2);       // resumes at beat 4
        add(-1, 0, 1, 1, 0, 1);
        add(-1, 0, 1, 0, 0, 1);
        // D: requester 3 drains after 2 beats, and requester 0 follows.
        s3 = tbl.size();
        add(-1, 0, 1, 0, 0, 0);
        add( 0, 3, 1, 1, 1, 3);
        add(-1, 0, 1, 1, 1, 3);
        add(-1, 0, 1, 1, 0, 3);
        add(-1, 0, 1, 0, 0, 3);
        add(-1, 0, 1, 1, 1, 0, 3);
        add(-1, 0, 1, 1, 0, 0);
        add(-1, 0, 1, 0, 0, 0);
        s4 = tbl.size();

        do_reset();
        rem[2] = 10;
        run_range(s0, s1);
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 50;
        run_range(s1, s2);
        do_reset();                       // reset while a grant is active
        rem[1] = 6;
        run_range(s2, s3);
        do_reset();
        rem[3] = 2;
        run_range(s3, s4);
`else
        // Packet lock: a 6-beat packet from 0 stays contiguous, then 1 follows.
        s0 = tbl.size();
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 0, 6);
        add(-1, 0, 1, 0, 0, 0);
        add(-1, 0, 1, 1, 1, 1, 3);
        add(-1, 0, 1, 0, 0, 1);
        s1 = tbl.size();
        s2 = 0; s3 = 0; s4 = 0;
        do_reset();
        rem[0] = 6;
        rem[1] = 3;
        run_range(s0, s1);
`endif

        // N=3: a grant to requester 2 wraps ptr to 0, so 0 beats 2 next.
        @(negedge clk);
        reset = 1'b1;
        v3    = 3'b000;
        d3    = {32'hC2, 32'hC1, 32'hC0};
        ordy3 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        v3    = 3'b100;
        #1;
        check("n3 idle busy", busy3, 0);
        @(negedge clk);
        #1;
        check("n3 grant busy", busy3, 1);
        check("n3 grant src", src3, 2);
        check("n3 grant data", od3, 32'hC2);
        $display("[TB] n3 grant src=%0d data=%08h", src3, od3);
        @(negedge clk);
        v3 = 3'b000;
        #1;
        check("n3 drain val", ov3, 0);
        check("n3 drain busy", busy3, 1);
        @(negedge clk);
        v3 = 3'b101;
        #1;
        check("n3 bubble busy", busy3, 0);
        @(negedge clk);
        #1;
        check("n3 wrap busy", busy3, 1);
        check("n3 wrap src", src3, 0);
        check("n3 wrap data", od3, 32'hC0);
        $display("[TB] n3 wrap src=%0d data=%08h", src3, od3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready consumer between N upstream fifo instances. It selects a requester, then passes that requester's head-of-queue data straight through for a bounded burst. It then rotates priority so no queue starves. It sits between a bank of fifos and a single shared datapath, for example a memory write port or a serializer.

## Interface
- WIDTH, 32, data width per requester
- N, 4, number of requesters (≥2)
- MAX_BURST, 4, maximum transfers per grant (≥1)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_data  in  N*WIDTH  requester i data at [i*WIDTH +: WIDTH]; connects to fifo data_out
- req_val  in  N  requester valid; connects to fifo data_out_val
- req_last  in  N  end-of-packet marker for the head beat (used only with ARB_LAST_LOCK_EN)
- req_rdy  out  N  pop strobe qualifier back to each fifo (data_out_rdy)
- out_data  out  WIDTH  granted requester's data
- out_val  out  1  output valid
- out_last  out  1  req_last of granted requester
- out_rdy  in  1  downstream ready
- out_src  out  $clog2(N)  index of current grant
- busy  out  1  high while in GRANT state

## Operation
- State: state {IDLE, GRANT}, grant index `g`, priority pointer `ptr` (both $clog2(N) bits), burst counter `cnt` ($clog2(MAX_BURST+1) bits).
- IDLE: if any req_val is set, the next `g` is the first set bit scanning ptr, ptr+1, … modulo N, and the next state is GRANT with cnt=0. Otherwise the block stays in IDLE. No transfer occurs in IDLE.
- GRANT: out_val = req_val[g]; out_data = req_data[g]; out_last = req_last[g]; req_rdy = one-hot(g) & {N{out_rdy}}. All other req_rdy bits are 0. Output paths are combinational from inputs.
- Transfer = out_val && out_rdy. Each transfer increments cnt.
- Release (next state IDLE, ptr ← g+1 mod N) when either condition holds:
  - a transfer occurs with cnt+1 == MAX_BURST;
  - req_val[g] is low during GRANT (the queue has drained), whether or not out_rdy is high.
- out_rdy low with req_val[g] high: hold the grant. cnt and data are unchanged.
- A requester whose req_val drops cannot hold the grant. Releasing on an empty queue is mandatory, so there are no dead cycles waiting on an empty fifo.
- N not a power of two: ptr and g wrap at N-1 → 0. Indices ≥N are never produced.
- Reset mid-GRANT: everything returns to reset values on the next edge. Any transfer on that cycle completes upstream only if out_rdy was high before the edge.

## Timing
- Reset values: state=IDLE, g=0, ptr=0, cnt=0. Outputs: out_val=0, req_rdy=0, out_src=0, busy=0, out_last=0.
- Arbitration latency is 1 cycle: a request seen in IDLE at cycle t gives out_val at t+1.
- Each grant has exactly one IDLE bubble cycle between consecutive grants.
- Peak throughput is MAX_BURST/(MAX_BURST+1) beats per cycle with continuous traffic.
- out_src is registered (= g). In IDLE it holds the last grant.
- Simultaneous requests are resolved strictly by ptr order. Lower index never wins by default.

## Configuration
- ARB_LAST_LOCK_EN defined:
  - The grant is held until a transfer with req_last[g]=1; MAX_BURST is ignored.
  - Release still occurs if req_val[g] drops, so a partially queued packet yields the grant. Upstream must fully enqueue packets before asserting valid.
- Undefined: req_last is ignored for arbitration, and release follows the MAX_BURST/drain rules. out_last still passes req_last[g] through.

## Test plan
- Single requester, N=4: req_val=4'b0100 with 10 queued beats and out_rdy=1. Expect bursts of 4, 4, 2 beats with out_src=2 each time, one bubble between bursts, and ptr=3 after each release.
- All four requesters continuously valid after reset, out_rdy=1. Expect grant order 0,1,2,3,0 with 4 beats each and 5 cycles per grant.
- Backpressure: out_rdy toggles 1,0,1,0 during a burst from requester 1. Expect no beat dropped or duplicated, cnt advancing only on transfers, and 4 transfers total before release.
- Drain: requester 3 has 2 beats and MAX_BURST=4. Expect 2 transfers, then release on the cycle req_val[3]=0, with requester 0 granted next if valid.
- N=3 wrap: grant to requester 2 releases with ptr=0. With requesters 0 and 2 both valid, expect 0 granted next.
- ARB_LAST_LOCK_EN: requester 0 sends a 6-beat packet with req_last on beat 6 while requester 1 is valid. Expect all 6 beats from source 0 contiguously, then source 1.
